// File: rtl/mips32_prog_loader.sv
// Host-side load/run/readback controller for the pipe_MIPS32 core: streams a
// program into core memory, runs the core until HLT or timeout, then dumps registers.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int DUMP_REGS = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_start,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic [4:0]        dump_idx,
  output logic              busy,
  output logic              timeout_err,
  output logic              done
);

  localparam int RUN_W = $clog2(TIMEOUT) + 1;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] MASK_CYC  = RUN_W'(2);
  localparam logic [4:0]       LAST_IDX  = 5'(DUMP_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, DUMP_RD, DUMP_OUT, DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wcnt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic                last_word;
  logic [RUN_W-1:0]    run_cnt;
  logic [4:0]          idx;
  logic [4:0]          idx_inc;
  logic                accept;
  logic                dump_hs;
  logic                tmo_hit;

  // wcnt holds the address of the last word written; the first word always lands at 0
  assign wr_addr_nxt = (state == IDLE) ? '0 : wcnt + ADDR_W'(1);
  assign last_word   = cmd_last | (wr_addr_nxt == '1);
  assign idx_inc     = idx + 5'd1;

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    cpu_start  = 1'b0;
    cpu_run    = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
      end
      LOAD:  cmd_ready = 1'b1;
      START: begin
        cpu_start = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        cpu_run = 1'b1;
        // the first two RUN cycles may still show HALTED left over from a previous run
        if ((run_cnt >= MASK_CYC) && cpu_halted) begin
          state_nxt = DUMP_RD;
        end else if (run_cnt == RUN_LIMIT) begin
          tmo_hit   = 1'b1;
          state_nxt = DUMP_RD;
        end
      end
      DUMP_RD: state_nxt = DUMP_OUT;
      DUMP_OUT: begin
        dump_valid = 1'b1;
        if (dump_ready) state_nxt = (idx == LAST_IDX) ? DONE : DUMP_RD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = cmd_valid & cmd_ready;
    if (accept) state_nxt = last_word ? START : LOAD;
    dump_hs = dump_valid & dump_ready;
    // present the next index during the handshake so the one-cycle register read
    // has settled by the end of DUMP_RD
    reg_raddr = dump_hs ? idx_inc : idx;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      run_cnt     <= '0;
      idx         <= '0;
      timeout_err <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      dump_data   <= '0;
      dump_idx    <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= wr_addr_nxt;
        mem_wdata <= cmd_data;
        wcnt      <= wr_addr_nxt;
      end
      if (accept && (state == IDLE)) timeout_err <= 1'b0;
      else if (tmo_hit)              timeout_err <= 1'b1;
      if (state == START)    run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + RUN_W'(1);
      if (state == DUMP_RD) begin
        dump_data <= reg_rdata;
        dump_idx  <= idx;
      end
      if (dump_hs) idx <= idx_inc;
      if (state == DONE) begin
        idx     <= '0;
        wcnt    <= '0;
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: behavioural core model plus write/dump scoreboards,
// with a second small-address instance for the forced-last case.
module tb_mips32_prog_loader;

  typedef logic [31:0] vec6_t [6];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        cmd_last = 1'b0;
  logic        dump_ready = 1'b1;
  logic        cmd_ready, mem_we, cpu_start, cpu_run, cpu_halted;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, reg_rdata, dump_data;
  logic [4:0]  reg_raddr, dump_idx;
  logic        dump_valid, busy, timeout_err, done;

  logic        b_cmd_ready, b_mem_we, b_cpu_start, b_cpu_run;
  logic [2:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_dump_data;
  logic [4:0]  b_reg_raddr, b_dump_idx;
  logic        b_dump_valid, b_busy, b_timeout_err, b_done;

  mips32_prog_loader #(.ADDR_W(10), .DUMP_REGS(6), .TIMEOUT(20)) dut (
    .clk1(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_start(cpu_start), .cpu_run(cpu_run),
    .cpu_halted(cpu_halted), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .busy(busy), .timeout_err(timeout_err), .done(done)
  );

  mips32_prog_loader #(.ADDR_W(3), .DUMP_REGS(6), .TIMEOUT(20)) dut_b (
    .clk1(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_data(cmd_data), .cmd_last(1'b0), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .cpu_start(b_cpu_start), .cpu_run(b_cpu_run),
    .cpu_halted(1'b1), .reg_raddr(b_reg_raddr), .reg_rdata(32'h0),
    .dump_valid(b_dump_valid), .dump_ready(dump_ready), .dump_data(b_dump_data),
    .dump_idx(b_dump_idx), .busy(b_busy), .timeout_err(b_timeout_err), .done(b_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sequential reference core: ADD, OR, ADDI, HLT; one instruction per enabled cycle
  logic [31:0] imem [0:1023];
  logic [31:0] regs [0:31];
  logic [9:0]  pc;
  logic        core_halted;
  logic [31:0] ins;
  bit          never_halt = 1'b0;
  bit          halt_tie = 1'b0;
  bit          core_clr = 1'b1;
  bit          sparse = 1'b0;
  bit          b_check = 1'b0;

  assign cpu_halted = halt_tie | core_halted;

  always @(posedge clk) begin
    reg_rdata <= regs[reg_raddr];
    if (mem_we) imem[mem_addr] <= mem_wdata;
    if (core_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < 1024; i++) imem[i] <= '0;
      pc <= '0;
      core_halted <= 1'b0;
    end else if (cpu_start) begin
      pc <= '0;
      core_halted <= 1'b0;
    end else if (cpu_run && !core_halted) begin
      ins = imem[pc];
      pc <= pc + 10'd1;
      case (ins[31:26])
        6'h00: if (ins[15:11] != 0) regs[ins[15:11]] <= regs[ins[25:21]] + regs[ins[20:16]];
        6'h03: if (ins[15:11] != 0) regs[ins[15:11]] <= regs[ins[25:21]] | regs[ins[20:16]];
        6'h0a: if (ins[20:16] != 0) regs[ins[20:16]] <= regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
        6'h3f: if (!never_halt) core_halted <= 1'b1;
        default: ;
      endcase
    end
  end

  initial begin
    int rc = 0;
    forever begin
      @(posedge clk); #1;
      dump_ready = sparse ? (rc % 3 == 0) : 1'b1;
      rc++;
    end
  end

  logic [41:0] wq [$];
  logic [36:0] dq [$];
  logic [34:0] bq [$];
  logic [41:0] we_e;
  logic [36:0] de_e;
  logic [34:0] be_e;
  bit          held_vld = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_idx;
  int start_cnt = 0, run_cyc = 0, done_cnt = 0, b_start_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) chk("wr_extra", 1, 0);
      else begin
        we_e = wq.pop_front();
        chk("wr_addr", mem_addr, we_e[41:32]);
        chk("wr_data", mem_wdata, we_e[31:0]);
      end
    end
    if (b_check && b_mem_we) begin
      if (bq.size() == 0) chk("b_wr_extra", 1, 0);
      else begin
        be_e = bq.pop_front();
        chk("b_wr_addr", b_mem_addr, be_e[34:32]);
        chk("b_wr_data", b_mem_wdata, be_e[31:0]);
      end
    end
    if (held_vld) begin
      chk("dump_valid_hold", dump_valid, 1);
      chk("dump_data_hold", dump_data, held_data);
      chk("dump_idx_hold", dump_idx, held_idx);
    end
    held_vld  = dump_valid && !dump_ready;
    held_data = dump_data;
    held_idx  = dump_idx;
    if (dump_valid && dump_ready) begin
      if (dq.size() == 0) chk("dump_extra", 1, 0);
      else begin
        de_e = dq.pop_front();
        chk("dump_data", dump_data, de_e[31:0]);
        chk("dump_idx", dump_idx, de_e[36:32]);
      end
    end
    start_cnt   += int'(cpu_start);
    run_cyc     += int'(cpu_run);
    done_cnt    += int'(done);
    b_start_cnt += int'(b_cpu_start);
  end

  logic [31:0] prog [0:9];
  logic [9:0]  wr_addr;
  vec6_t full_v, part_v, zero_v;

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic clr_core();
    @(posedge clk); #1; core_clr = 1'b1;
    @(posedge clk); #1; core_clr = 1'b0;
  endtask

  task automatic push_dumps(input vec6_t v);
    for (int k = 0; k < 6; k++) dq.push_back({5'(k), v[k]});
  endtask

  task automatic load_prog(input int base, input int n, input bit last, input bit gaps);
    int i, cyc;
    i = 0; cyc = 0; wr_addr = '0;
    while (i < n && cyc < 200) begin
      @(posedge clk); #1;
      cmd_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      cmd_data  = prog[base + i];
      cmd_last  = last && (i == n - 1);
      @(negedge clk);
      if (cmd_valid && cmd_ready && !rst) begin
        wq.push_back({wr_addr, prog[base + i]});
        wr_addr++;
        i++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    chk("load_accepted", i, n);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk($sformatf("%s.done_seen", tag), i < 400, 1);
  endtask

  task automatic run_prog(input string tag, input bit gaps, input bit sp, input vec6_t v,
                          input int exp_run, input bit exp_tmo);
    int s0, r0, d0;
    clr_core();
    s0 = start_cnt; r0 = run_cyc; d0 = done_cnt;
    sparse = sp;
    push_dumps(v);
    load_prog(0, 9, 1'b1, gaps);
    wait_done(tag);
    @(negedge clk);
    sparse = 1'b0;
    chk($sformatf("%s.start_pulses", tag), start_cnt - s0, 1);
    chk($sformatf("%s.done_pulses", tag), done_cnt - d0, 1);
    if (exp_run >= 0) chk($sformatf("%s.run_cycles", tag), run_cyc - r0, exp_run);
    chk($sformatf("%s.timeout_err", tag), timeout_err, exp_tmo);
    chk($sformatf("%s.wr_missing", tag), wq.size(), 0);
    chk($sformatf("%s.dump_missing", tag), dq.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk($sformatf("%s.cmd_ready", tag), cmd_ready, 1);
    chk($sformatf("%s.cpu_run", tag), cpu_run, 0);
    chk($sformatf("%s.cpu_start", tag), cpu_start, 0);
    chk($sformatf("%s.mem_we", tag), mem_we, 0);
    chk($sformatf("%s.mem_addr", tag), mem_addr, 0);
    chk($sformatf("%s.mem_wdata", tag), mem_wdata, 0);
    chk($sformatf("%s.busy", tag), busy, 0);
    chk($sformatf("%s.dump_valid", tag), dump_valid, 0);
    chk($sformatf("%s.dump_data", tag), dump_data, 0);
    chk($sformatf("%s.dump_idx", tag), dump_idx, 0);
    chk($sformatf("%s.reg_raddr", tag), reg_raddr, 0);
    chk($sformatf("%s.timeout_err", tag), timeout_err, 0);
    chk($sformatf("%s.done", tag), done, 0);
  endtask

  task automatic fresh_hlt(input string tag);
    int s0;
    clr_core();
    s0 = start_cnt;
    push_dumps(zero_v);
    load_prog(8, 1, 1'b1, 1'b0);
    wait_done(tag);
    @(negedge clk);
    chk($sformatf("%s.start_pulses", tag), start_cnt - s0, 1);
    chk($sformatf("%s.wr_missing", tag), wq.size(), 0);
    chk($sformatf("%s.dump_missing", tag), dq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, k;
    prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
    prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
    prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
    prog[9] = 32'h0;
    full_v = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
    part_v = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd0, 32'd0};
    zero_v = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    repeat (3) @(posedge clk);
    #1; rst = 1'b0; core_clr = 1'b0;
    @(negedge clk);
    check_reset("por");

    run_prog("basic", 1'b0, 1'b0, full_v, -1, 1'b0);
    run_prog("gaps", 1'b1, 1'b1, full_v, -1, 1'b0);

    never_halt = 1'b1;
    run_prog("tmo", 1'b0, 1'b0, full_v, 20, 1'b1);
    never_halt = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo.sticky_idle", timeout_err, 1);

    halt_tie = 1'b1;
    repeat (3) @(negedge clk);
    run_prog("halt_tied", 1'b0, 1'b0, part_v, 3, 1'b0);
    halt_tie = 1'b0;

    // small-address instance: eight words fill memory and force the run
    pulse_rst();
    b_check = 1'b1;
    s0 = b_start_cnt;
    wr_addr = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_data  = 32'ha000_0000 + 32'(i);
      cmd_last  = 1'b0;
      @(negedge clk);
      chk($sformatf("b.cmd_ready[%0d]", i), b_cmd_ready, i < 8);
      if (b_cmd_ready) bq.push_back({3'(i), cmd_data});
      if (cmd_ready) begin
        wq.push_back({wr_addr, cmd_data});
        wr_addr++;
      end
    end
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b.start_pulses", b_start_cnt - s0, 1);
    chk("b.wr_missing", bq.size(), 0);
    chk("a.wr_missing", wq.size(), 0);
    b_check = 1'b0;

    // reset in the middle of a load, with a word offered on the reset edge
    pulse_rst();
    clr_core();
    load_prog(0, 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; cmd_valid = 1'b1; cmd_data = 32'hdeadbeef;
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check_reset("rst_load");
    fresh_hlt("after_rst_load");

    // reset while the core is running
    never_halt = 1'b1;
    clr_core();
    load_prog(0, 9, 1'b1, 1'b0);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cpu_run) break;
    end
    chk("rst_run.run_seen", k < 50, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_reset("rst_run");
    never_halt = 1'b0;
    fresh_hlt("after_rst_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
